// File: rtl/vx_commit_if.sv
// Commit-stage bus: execute-unit result streams in, per-slot register writeback out.
// slave = commit stage, master = execute units / writeback consumer.
interface vx_commit_if #(
  parameter int ISSUE_WIDTH  = 1,
  parameter int NUM_EX_UNITS = 4,
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int UUID_WIDTH   = 44,
  parameter int PC_BITS      = 32
);
  localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NR_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WIS_BITS = ((NUM_WARPS / ISSUE_WIDTH) > 1) ? $clog2(NUM_WARPS / ISSUE_WIDTH) : 1;

  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0]                       cm_valid;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0]                       cm_ready;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0][UUID_WIDTH-1:0]       cm_uuid;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0][WID_BITS-1:0]         cm_wid;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0][NUM_THREADS-1:0]      cm_tmask;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0][PC_BITS-1:0]          cm_pc;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0]                       cm_wb;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0]                       cm_sop;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0]                       cm_eop;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0][NR_BITS-1:0]          cm_rd;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0][NUM_THREADS-1:0][XLEN-1:0] cm_data;

  logic [ISSUE_WIDTH-1:0]                                         wb_valid;
  logic [ISSUE_WIDTH-1:0][UUID_WIDTH-1:0]                         wb_uuid;
  logic [ISSUE_WIDTH-1:0][WIS_BITS-1:0]                           wb_wis;
  logic [ISSUE_WIDTH-1:0][NUM_THREADS-1:0]                        wb_tmask;
  logic [ISSUE_WIDTH-1:0][PC_BITS-1:0]                            wb_pc;
  logic [ISSUE_WIDTH-1:0][NR_BITS-1:0]                            wb_rd;
  logic [ISSUE_WIDTH-1:0][NUM_THREADS-1:0][XLEN-1:0]              wb_data;
  logic [ISSUE_WIDTH-1:0]                                         wb_sop;
  logic [ISSUE_WIDTH-1:0]                                         wb_eop;

  modport slave (
    input  cm_valid, cm_uuid, cm_wid, cm_tmask, cm_pc, cm_wb, cm_sop, cm_eop, cm_rd, cm_data,
    output cm_ready,
    output wb_valid, wb_uuid, wb_wis, wb_tmask, wb_pc, wb_rd, wb_data, wb_sop, wb_eop
  );

  modport master (
    output cm_valid, cm_uuid, cm_wid, cm_tmask, cm_pc, cm_wb, cm_sop, cm_eop, cm_rd, cm_data,
    input  cm_ready,
    input  wb_valid, wb_uuid, wb_wis, wb_tmask, wb_pc, wb_rd, wb_data, wb_sop, wb_eop
  );
endinterface

// File: rtl/vx_commit.sv
// Commit stage: per-slot round-robin pick among execute units, winner registered (1 cycle) to writeback.
// Never backpressures beyond arbitration: cm_ready is the combinational grant; forced low in reset.
module vx_commit #(
  parameter int ISSUE_WIDTH   = 1,
  parameter int NUM_EX_UNITS  = 4,
  parameter int NUM_WARPS     = 4,
  parameter int NUM_THREADS   = 4,
  parameter int XLEN          = 32,
  parameter int NUM_REGS      = 32,
  parameter int UUID_WIDTH    = 44,
  parameter int PC_BITS       = 32,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                              clk,
  input  logic                              reset,
  vx_commit_if.slave                        bus,
  output logic [NUM_WARPS-1:0]              committed_warps,
  output logic [PERF_CTR_BITS-1:0]          instret,
  output logic [NUM_REGS-1:0][XLEN-1:0]     sim_wb_value
);
  localparam int UB       = (NUM_EX_UNITS > 1) ? $clog2(NUM_EX_UNITS) : 1;
  localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int WIS_BITS = ((NUM_WARPS / ISSUE_WIDTH) > 1) ? $clog2(NUM_WARPS / ISSUE_WIDTH) : 1;
  localparam int ISB      = $clog2(ISSUE_WIDTH);
  localparam int CNT_BITS = $clog2(ISSUE_WIDTH + 1);

  logic [ISSUE_WIDTH-1:0][UB-1:0]           prio;
  logic [ISSUE_WIDTH-1:0][UB-1:0]           win;
  logic [ISSUE_WIDTH-1:0][NUM_EX_UNITS-1:0] gnt;
  logic [ISSUE_WIDTH-1:0]                   fire;
  logic [NUM_WARPS-1:0]                     next_cw;
  logic [CNT_BITS-1:0]                      ret_cnt;

  // Rotating-priority search: first valid unit at or after the pointer wins.
  always_comb begin
    logic [UB-1:0] idx;
    idx  = '0;
    gnt  = '0;
    win  = '0;
    fire = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      for (int k = 0; k < NUM_EX_UNITS; k++) begin
        idx = UB'((int'(prio[s]) + k) % NUM_EX_UNITS);
        if (!reset && !fire[s] && bus.cm_valid[s][idx]) begin
          fire[s]     = 1'b1;
          gnt[s][idx] = 1'b1;
          win[s]      = idx;
        end
      end
    end
  end

  assign bus.cm_ready = gnt;

  always_comb begin
    next_cw = '0;
    ret_cnt = '0;
    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      if (fire[s] && bus.cm_eop[s][win[s]]) begin
        next_cw[bus.cm_wid[s][win[s]]] = 1'b1;
        ret_cnt = ret_cnt + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio            <= '0;
      bus.wb_valid    <= '0;
      bus.wb_uuid     <= '0;
      bus.wb_wis      <= '0;
      bus.wb_tmask    <= '0;
      bus.wb_pc       <= '0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
      bus.wb_sop      <= '0;
      bus.wb_eop      <= '0;
      committed_warps <= '0;
      instret         <= '0;
      sim_wb_value    <= '0;
    end else begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
        bus.wb_valid[s] <= fire[s] & bus.cm_wb[s][win[s]];
        if (fire[s]) begin
          prio[s]         <= UB'((int'(win[s]) + 1) % NUM_EX_UNITS);
          bus.wb_uuid[s]  <= bus.cm_uuid[s][win[s]];
          bus.wb_wis[s]   <= WIS_BITS'(bus.cm_wid[s][win[s]] >> ISB);
          bus.wb_tmask[s] <= bus.cm_tmask[s][win[s]];
          bus.wb_pc[s]    <= bus.cm_pc[s][win[s]];
          bus.wb_rd[s]    <= bus.cm_rd[s][win[s]];
          bus.wb_data[s]  <= bus.cm_data[s][win[s]];
          bus.wb_sop[s]   <= bus.cm_sop[s][win[s]];
          bus.wb_eop[s]   <= bus.cm_eop[s][win[s]];
        end
      end
      committed_warps <= next_cw;
      instret         <= instret + PERF_CTR_BITS'(ret_cnt);
      // Shadow copy tracks only slot 0, lane 0 of each committed write.
      if (bus.wb_valid[0] && bus.wb_tmask[0][0])
        sim_wb_value[bus.wb_rd[0]] <= bus.wb_data[0][0];
    end
  end

  logic unused_wid;
  assign unused_wid = ^{WID_BITS{1'b0}};
endmodule

// File: tb/tb_vx_commit.sv
// Directed bench for vx_commit: arbitration order, writeback, retire pulses, instret, shadow regs, reset.
module tb_vx_commit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_commit_if bus ();
  logic [3:0]        committed_warps;
  logic [43:0]       instret;
  logic [31:0][31:0] sim_wb_value;

  vx_commit dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave),
    .committed_warps (committed_warps),
    .instret         (instret),
    .sim_wb_value    (sim_wb_value)
  );

  int checks = 0;
  int errors = 0;
  int acc [4];
  logic [1:0] eu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    bus.cm_valid = '0;
    bus.cm_uuid  = '0;
    bus.cm_wid   = '0;
    bus.cm_tmask = '0;
    bus.cm_pc    = '0;
    bus.cm_wb    = '0;
    bus.cm_sop   = '0;
    bus.cm_eop   = '0;
    bus.cm_rd    = '0;
    bus.cm_data  = '0;
  endtask

  task automatic drive(input logic [1:0] u, input logic [1:0] wid, input logic [3:0] tmask,
                       input logic [4:0] rd, input logic wb, input logic sop, input logic eop,
                       input logic [31:0] d0);
    bus.cm_valid[0][u]   = 1'b1;
    bus.cm_uuid[0][u]    = 44'd100 + 44'(u);
    bus.cm_wid[0][u]     = wid;
    bus.cm_tmask[0][u]   = tmask;
    bus.cm_pc[0][u]      = 32'h1000 + {28'd0, u, 2'b00};
    bus.cm_wb[0][u]      = wb;
    bus.cm_sop[0][u]     = sop;
    bus.cm_eop[0][u]     = eop;
    bus.cm_rd[0][u]      = rd;
    bus.cm_data[0][u][0] = d0;
    bus.cm_data[0][u][1] = ~d0;
  endtask

  initial begin
    reset = 1'b1;
    clear_all();
    for (int u = 0; u < 4; u++) drive(2'(u), 2'(u), 4'hF, 5'(u + 1), 1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    tick();
    check("ready_in_reset", 64'(bus.cm_ready[0]), 64'h0);
    check("rst_wb_valid", 64'(bus.wb_valid[0]), 64'h0);
    check("rst_committed", 64'(committed_warps), 64'h0);
    check("rst_instret", 64'(instret), 64'h0);
    check("rst_sim_reg1", 64'(sim_wb_value[1]), 64'h0);
    check("rst_wb_rd", 64'(bus.wb_rd[0]), 64'h0);

    // Single ALU commit
    clear_all();
    reset = 1'b0;
    drive(2'd0, 2'd2, 4'b1011, 5'd5, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
    #1;
    check("alu_ready", 64'(bus.cm_ready[0]), 64'h1);
    tick();
    clear_all();
    check("alu_wb_valid", 64'(bus.wb_valid[0]), 64'h1);
    check("alu_wb_rd", 64'(bus.wb_rd[0]), 64'd5);
    check("alu_wb_tmask", 64'(bus.wb_tmask[0]), 64'hB);
    check("alu_wb_wis", 64'(bus.wb_wis[0]), 64'd2);
    check("alu_wb_pc", 64'(bus.wb_pc[0]), 64'h1000);
    check("alu_wb_uuid", 64'(bus.wb_uuid[0]), 64'd100);
    check("alu_wb_data0", 64'(bus.wb_data[0][0]), 64'h1234_5678);
    check("alu_committed", 64'(committed_warps), 64'h4);
    check("alu_instret", 64'(instret), 64'd1);
    tick();
    check("alu_committed_pulse", 64'(committed_warps), 64'h0);
    check("alu_wb_valid_drop", 64'(bus.wb_valid[0]), 64'h0);
    check("alu_sim_reg5", 64'(sim_wb_value[5]), 64'h1234_5678);

    // All four units contending; pointer sits at LSU after the ALU win.
    for (int u = 0; u < 4; u++) begin
      acc[u] = 0;
      drive(2'(u), 2'(u), 4'hF, 5'(u + 1), 1'b1, 1'b1, 1'b1, 32'(u));
    end
    for (int i = 0; i < 8; i++) begin
      eu = 2'(1 + i);
      #1;
      check("rr_grant", 64'(bus.cm_ready[0]), 64'h1 << eu);
      if (bus.cm_ready[0][0]) acc[0]++;
      if (bus.cm_ready[0][1]) acc[1]++;
      if (bus.cm_ready[0][2]) acc[2]++;
      if (bus.cm_ready[0][3]) acc[3]++;
      tick();
      check("rr_wb_rd", 64'(bus.wb_rd[0]), 64'(eu) + 64'd1);
    end
    clear_all();
    for (int u = 0; u < 4; u++) check("rr_accept_count", 64'(acc[u]), 64'd2);
    check("rr_instret", 64'(instret), 64'd9);
    check("rr_committed_last", 64'(committed_warps), 64'h1);
    tick();

    // Store-like: retires without a register write
    drive(2'd1, 2'd3, 4'hF, 5'd9, 1'b0, 1'b1, 1'b1, 32'h5555);
    #1;
    check("st_ready", 64'(bus.cm_ready[0]), 64'h2);
    tick();
    clear_all();
    check("st_wb_valid", 64'(bus.wb_valid[0]), 64'h0);
    check("st_committed", 64'(committed_warps), 64'h8);
    check("st_instret", 64'(instret), 64'd10);
    tick();
    check("st_committed_pulse", 64'(committed_warps), 64'h0);

    // Two-packet instruction on the FPU
    drive(2'd2, 2'd1, 4'hF, 5'd7, 1'b1, 1'b1, 1'b0, 32'hAAAA);
    tick();
    check("mp1_wb_valid", 64'(bus.wb_valid[0]), 64'h1);
    check("mp1_wb_sop_eop", 64'({bus.wb_sop[0], bus.wb_eop[0]}), 64'b10);
    check("mp1_committed", 64'(committed_warps), 64'h0);
    check("mp1_instret", 64'(instret), 64'd10);
    drive(2'd2, 2'd1, 4'hF, 5'd7, 1'b1, 1'b0, 1'b1, 32'hBBBB);
    tick();
    clear_all();
    check("mp2_wb_valid", 64'(bus.wb_valid[0]), 64'h1);
    check("mp2_wb_sop_eop", 64'({bus.wb_sop[0], bus.wb_eop[0]}), 64'b01);
    check("mp2_committed", 64'(committed_warps), 64'h2);
    check("mp2_instret", 64'(instret), 64'd11);
    tick();
    check("mp2_committed_pulse", 64'(committed_warps), 64'h0);

    // Shadow register file
    check("sim10_init", 64'(sim_wb_value[10]), 64'h0);
    drive(2'd0, 2'd0, 4'b0001, 5'd10, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    clear_all();
    tick();
    check("sim10_write", 64'(sim_wb_value[10]), 64'hDEAD_BEEF);
    drive(2'd0, 2'd0, 4'b1110, 5'd10, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    tick();
    clear_all();
    tick();
    check("sim10_masked", 64'(sim_wb_value[10]), 64'hDEAD_BEEF);
    check("sim_instret", 64'(instret), 64'd13);

    // Reset mid-stream
    for (int u = 0; u < 4; u++) drive(2'(u), 2'(u), 4'hF, 5'(u + 1), 1'b1, 1'b1, 1'b1, 32'h77);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.cm_ready[0]), 64'h0);
    tick();
    check("mid_rst_wb_valid", 64'(bus.wb_valid[0]), 64'h0);
    check("mid_rst_committed", 64'(committed_warps), 64'h0);
    check("mid_rst_instret", 64'(instret), 64'h0);
    check("mid_rst_sim10", 64'(sim_wb_value[10]), 64'h0);
    check("mid_rst_wb_data", 64'(bus.wb_data[0][0]), 64'h0);
    reset = 1'b0;
    #1;
    check("mid_rst_restart_alu", 64'(bus.cm_ready[0]), 64'h1);
    tick();
    clear_all();
    check("mid_rst_first_rd", 64'(bus.wb_rd[0]), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_commit.md
# vx_commit

Commit stage of the SIMT core. Per issue slot it arbitrates among the execute-unit result streams (ALU, LSU, FPU, SFU) and registers the winner. It drives the register-file writeback port, reports retired warps to the scheduler (commit_sched), and maintains the retired-instruction counter (commit_csr). It also keeps a simulation shadow of architectural register values.

## Interface
- ISSUE_WIDTH, 1: issue slots; all per-slot ports are arrays of this size.
- NUM_EX_UNITS, 4: unit index 0=ALU, 1=LSU, 2=FPU, 3=SFU.
- NUM_WARPS, 4; NUM_THREADS, 4; XLEN, 32; NUM_REGS, 32 (rd width NR_BITS=clog2(NUM_REGS)).
- UUID_WIDTH, 44; PC_BITS, 32; PERF_CTR_BITS, 44.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cm_valid  in  [ISSUE_WIDTH][NUM_EX_UNITS]  unit result valid.
- cm_ready  out  [ISSUE_WIDTH][NUM_EX_UNITS]  result accepted this cycle.
- cm_uuid / cm_wid / cm_tmask / cm_pc  in  UUID_WIDTH / clog2(NUM_WARPS) / NUM_THREADS / PC_BITS  per entry.
- cm_wb, cm_sop, cm_eop  in  1 each  register write, first / last packet of instruction.
- cm_rd  in  NR_BITS; cm_data  in  [NUM_THREADS][XLEN].
- wb_valid  out  [ISSUE_WIDTH]  register-file write.
- wb_uuid, wb_wis (clog2(NUM_WARPS/ISSUE_WIDTH), min 1), wb_tmask, wb_pc, wb_rd, wb_data, wb_sop, wb_eop  out  per slot.
- committed_warps  out  NUM_WARPS  (commit_sched) warps retiring an instruction.
- instret  out  PERF_CTR_BITS  (commit_csr) retired warp instructions.
- sim_wb_value  out  [NUM_REGS][XLEN]  shadow register file.

## Operation
- Per slot, one round-robin arbiter over NUM_EX_UNITS. Grant pointer advances to the unit after the winner on every fire; it holds when nothing fires.
- cm_ready[s][u] = grant[s][u] (combinational). The output stage never backpressures.
- fire[s] = any valid in slot s. The winner's fields are captured into an output register.
- wb_valid[s] = registered(fire[s] & cm_wb of winner). All wb_* fields are registered copies of the winner's fields.
- wb_wis = wid >> clog2(ISSUE_WIDTH).
- committed_warps: registered OR over slots of onehot(wid) for fires with eop=1. Two slots hitting the same warp produce a single bit.
- instret += number of slots firing with eop=1 that cycle. It counts warp instructions, not threads. It wraps modulo 2^PERF_CTR_BITS.
- sim_wb_value[rd] is updated from the slot-0 writeback when wb_valid[0] and wb_tmask[0] are set. It takes the value of wb_data[0] lane 0.
- Slots are independent. Ties within a slot are resolved by the rotating priority only.

## Timing
- Selection is combinational. wb_*, committed_warps and the instret increment appear 1 cycle after the fire.
- Reset values:
  - wb_valid = 0
  - committed_warps = 0
  - instret = 0
  - sim_wb_value = 0
  - arbiter priority = unit 0
  - wb data fields = 0
- During reset, cm_ready = 0.
- Full throughput: one commit per slot per cycle. A unit held valid against others is granted within NUM_EX_UNITS cycles.
- Multi-packet instructions (sop/eop split) count and retire only on eop. Non-eop packets still write registers.
- committed_warps is a one-cycle pulse per retire event.

## Test plan
- Single ALU commit, wid=2, tmask=4'b1011, rd=5, wb=1, eop=1:
  - cm_ready[0][0] is high the same cycle.
  - Next cycle: wb_valid=1, wb_rd=5, wb_tmask=1011.
  - committed_warps=4'b0100 for one cycle.
  - instret 0→1.
- ALU, LSU, FPU and SFU all valid continuously for 8 cycles → grants rotate 0,1,2,3,0,1,2,3; each unit is accepted twice; instret=8.
- Store-like commit with wb=0, eop=1 → wb_valid stays 0; committed_warps pulses; instret increments.
- Two-packet instruction (sop=1/eop=0, then sop=0/eop=1) → two writebacks, instret +1 only after the second, committed_warps pulses once.
- Writeback rd=10, tmask lane0 set, data lane0=0xDEADBEEF → sim_wb_value[10]=0xDEADBEEF next cycle. The same write with lane0 masked leaves sim_wb_value[10] unchanged.
- Assert reset mid-stream with units valid → cm_ready=0; all outputs return to 0; arbiter restarts at ALU.
